// File: rtl/date_counter_pkg.sv
// Shared constants and calendar helpers for the millennium clock date stage.
package clock_pkg;

  localparam logic [2:0] SEL_DAY_CODE   = 3'b011;
  localparam logic [2:0] SEL_MONTH_CODE = 3'b100;
  localparam logic [2:0] SEL_YEAR_CODE  = 3'b101;

  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;

  function automatic logic is_leap(input int unsigned y);
    return ((y % 4) == 0) && (((y % 100) != 0) || ((y % 400) == 0));
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
    if (m == FEB)
      return leap ? 5'd29 : 5'd28;
    else if ((m == APR) || (m == JUN) || (m == SEP) || (m == NOV))
      return 5'd30;
    else
      return 5'd31;
  endfunction

endpackage

// File: rtl/date_counter_if.sv
// Control inputs and date outputs of the calendar stage.
interface date_counter_if #(parameter int YEAR_W = 12);
  logic              en_1;
  logic              carry_in;
  logic              up;
  logic              down;
  logic [2:0]        select_item;
  logic [4:0]        day_bin;
  logic [3:0]        month_bin;
  logic [YEAR_W-1:0] year_bin;
  logic              leap_year;
  logic              wrap_out;

  modport master (
    output en_1, carry_in, up, down, select_item,
    input  day_bin, month_bin, year_bin, leap_year, wrap_out
  );

  modport slave (
    input  en_1, carry_in, up, down, select_item,
    output day_bin, month_bin, year_bin, leap_year, wrap_out
  );
endinterface

// File: rtl/date_counter_adj_wrap_counter.sv
// Up/down counter wrapping between MIN and a runtime upper bound, with load override.
module adj_wrap_counter #(
  parameter int W   = 5,
  parameter int MIN = 1
) (
  input  logic         clk_1Hz,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] max,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_en)
      cnt_d = load_val;
    else if (inc && !dec)
      cnt_d = (cnt_q >= max) ? W'(MIN) : cnt_q + 1'b1;
    else if (dec && !inc)
      cnt_d = (cnt_q <= W'(MIN)) ? max : cnt_q - 1'b1;
  end

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) cnt_q <= W'(MIN);
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/date_counter.sv
// Day/month/year calendar: carry-driven day advance in run mode, per-field
// up/down editing otherwise, leap-year aware with day clamping on edits.
module date_counter
  import clock_pkg::*;
#(
  parameter int         YEAR_W    = 12,
  parameter int         YEAR_MIN  = 2001,
  parameter int         YEAR_MAX  = 3000,
  parameter logic [2:0] SEL_DAY   = SEL_DAY_CODE,
  parameter logic [2:0] SEL_MONTH = SEL_MONTH_CODE,
  parameter logic [2:0] SEL_YEAR  = SEL_YEAR_CODE
) (
  input logic           clk_1Hz,
  input logic           rst_n,
  date_counter_if.slave dc
);

  logic              up_q, up_d, down_q, down_d, wrap_q, wrap_d;
  logic              up_s, dn_s, ed_day, ed_mon, ed_yr, run, step;
  logic              leap, day_end, mon_end, yr_end;
  logic              day_inc, day_dec, mon_inc, mon_dec, yr_inc, yr_dec, day_load;
  logic [4:0]        day, dim, clamp_dim;
  logic [3:0]        month, mon_nx;
  logic [YEAR_W-1:0] year, yr_nx;

  // Simultaneous rising edges on both buttons cancel out.
  assign up_s   = (dc.up & ~up_q) & ~(dc.down & ~down_q);
  assign dn_s   = (dc.down & ~down_q) & ~(dc.up & ~up_q);
  assign ed_day = (dc.select_item == SEL_DAY);
  assign ed_mon = (dc.select_item == SEL_MONTH);
  assign ed_yr  = (dc.select_item == SEL_YEAR);
  assign run    = ~(ed_day | ed_mon | ed_yr);
  assign step   = run & dc.en_1 & dc.carry_in;

  assign leap    = is_leap(32'(year));
  assign dim     = days_in_month(month, leap);
  assign day_end = (day == dim);
  assign mon_end = (month == DEC);
  assign yr_end  = (year == YEAR_W'(YEAR_MAX));

  assign day_inc = step | (ed_day & up_s);
  assign day_dec = ed_day & dn_s;
  assign mon_inc = (step & day_end) | (ed_mon & up_s);
  assign mon_dec = ed_mon & dn_s;
  assign yr_inc  = (step & day_end & mon_end) | (ed_yr & up_s);
  assign yr_dec  = ed_yr & dn_s;

  // Month/year edits predict the new field value so day can be clamped in the same cycle.
  always_comb begin
    mon_nx = month;
    yr_nx  = year;
    if (ed_mon & up_s)      mon_nx = mon_end ? 4'd1 : month + 1'b1;
    else if (ed_mon & dn_s) mon_nx = (month == 4'd1) ? DEC : month - 1'b1;
    if (ed_yr & up_s)       yr_nx = yr_end ? YEAR_W'(YEAR_MIN) : year + 1'b1;
    else if (ed_yr & dn_s)  yr_nx = (year == YEAR_W'(YEAR_MIN)) ? YEAR_W'(YEAR_MAX) : year - 1'b1;
  end

  assign clamp_dim = days_in_month(mon_nx, is_leap(32'(yr_nx)));
  assign day_load  = (ed_mon | ed_yr) & (day > clamp_dim);

  always_comb begin
    up_d   = dc.up;
    down_d = dc.down;
    wrap_d = step & day_end & mon_end & yr_end;
  end

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      up_q   <= up_d;
      down_q <= down_d;
      wrap_q <= wrap_d;
    end
  end

  adj_wrap_counter #(.W(5), .MIN(1)) u_day (
    .clk_1Hz (clk_1Hz), .rst_n (rst_n),
    .inc (day_inc), .dec (day_dec), .max (dim),
    .load_en (day_load), .load_val (clamp_dim), .cnt (day)
  );

  adj_wrap_counter #(.W(4), .MIN(1)) u_month (
    .clk_1Hz (clk_1Hz), .rst_n (rst_n),
    .inc (mon_inc), .dec (mon_dec), .max (DEC),
    .load_en (1'b0), .load_val (4'd0), .cnt (month)
  );

  adj_wrap_counter #(.W(YEAR_W), .MIN(YEAR_MIN)) u_year (
    .clk_1Hz (clk_1Hz), .rst_n (rst_n),
    .inc (yr_inc), .dec (yr_dec), .max (YEAR_W'(YEAR_MAX)),
    .load_en (1'b0), .load_val ({YEAR_W{1'b0}}), .cnt (year)
  );

  assign dc.day_bin   = day;
  assign dc.month_bin = month;
  assign dc.year_bin  = year;
  assign dc.leap_year = leap;
  assign dc.wrap_out  = wrap_q;

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: reset, leap rules, wrap, edit clamping, edge detection.
module tb_date_counter;

  localparam logic [2:0] S_RUN   = 3'b000;
  localparam logic [2:0] S_DAY   = 3'b011;
  localparam logic [2:0] S_MONTH = 3'b100;
  localparam logic [2:0] S_YEAR  = 3'b101;

  logic clk_1Hz;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  date_counter_if #(.YEAR_W(12)) dif ();

  date_counter #(
    .YEAR_W (12), .YEAR_MIN (2001), .YEAR_MAX (3000),
    .SEL_DAY (3'b011), .SEL_MONTH (3'b100), .SEL_YEAR (3'b101)
  ) dut (
    .clk_1Hz (clk_1Hz),
    .rst_n   (rst_n),
    .dc      (dif.slave)
  );

  initial clk_1Hz = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_date(input string tag, input int d, input int m, input int y);
    check_val({tag, " day"},   int'(dif.day_bin),   d);
    check_val({tag, " month"}, int'(dif.month_bin), m);
    check_val({tag, " year"},  int'(dif.year_bin),  y);
  endtask

  task automatic tick();
    @(posedge clk_1Hz);
    #1;
  endtask

  task automatic press(input logic [2:0] sel, input bit dir_up, input int n);
    dif.select_item = sel;
    for (int i = 0; i < n; i++) begin
      if (dir_up) dif.up = 1'b1;
      else        dif.down = 1'b1;
      tick();
      dif.up   = 1'b0;
      dif.down = 1'b0;
      tick();
    end
  endtask

  task automatic carry_pulse();
    dif.select_item = S_RUN;
    dif.en_1        = 1'b1;
    dif.carry_in    = 1'b1;
    tick();
    dif.carry_in    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    dif.en_1 = 1'b0; dif.carry_in = 1'b0; dif.up = 1'b0; dif.down = 1'b0;
    dif.select_item = S_RUN;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: async reset mid-edit
    check_date("post_reset", 1, 1, 2001);
    press(S_DAY, 1'b1, 4);
    press(S_MONTH, 1'b1, 2);
    press(S_YEAR, 1'b1, 1);
    check_date("pre_reset", 5, 3, 2002);
    dif.select_item = S_MONTH;
    dif.up = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_date("async_reset", 1, 1, 2001);
    check_val("reset_leap", int'(dif.leap_year), 0);
    check_val("reset_wrap", int'(dif.wrap_out), 0);
    dif.up = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // 2: leap year 2004
    press(S_YEAR, 1'b1, 3);
    check_val("y2004 year", int'(dif.year_bin), 2004);
    check_val("y2004 leap", int'(dif.leap_year), 1);
    press(S_MONTH, 1'b1, 1);
    press(S_DAY, 1'b1, 27);
    check_date("2004 setup", 28, 2, 2004);
    carry_pulse();
    check_date("2004 feb29", 29, 2, 2004);
    carry_pulse();
    check_date("2004 mar1", 1, 3, 2004);

    // 3: century rules
    do_reset();
    press(S_YEAR, 1'b1, 99);
    press(S_MONTH, 1'b1, 1);
    press(S_DAY, 1'b1, 27);
    check_date("2100 setup", 28, 2, 2100);
    check_val("2100 leap", int'(dif.leap_year), 0);
    carry_pulse();
    check_date("2100 mar1", 1, 3, 2100);
    press(S_YEAR, 1'b1, 300);
    press(S_MONTH, 1'b0, 1);
    press(S_DAY, 1'b1, 27);
    check_date("2400 setup", 28, 2, 2400);
    check_val("2400 leap", int'(dif.leap_year), 1);
    carry_pulse();
    check_date("2400 feb29", 29, 2, 2400);

    // 4: end-of-range wrap
    do_reset();
    press(S_YEAR, 1'b0, 1);
    check_val("year down wrap", int'(dif.year_bin), 3000);
    press(S_MONTH, 1'b0, 1);
    press(S_DAY, 1'b0, 1);
    check_date("3000 setup", 31, 12, 3000);
    check_val("wrap idle", int'(dif.wrap_out), 0);
    carry_pulse();
    check_date("range wrap", 1, 1, 2001);
    check_val("wrap pulse", int'(dif.wrap_out), 1);
    tick();
    check_val("wrap one cycle", int'(dif.wrap_out), 0);
    press(S_YEAR, 1'b0, 1);
    check_val("year down again", int'(dif.year_bin), 3000);

    // 5: clamping and day wrap on edits
    do_reset();
    press(S_DAY, 1'b0, 1);
    check_date("jan31", 31, 1, 2001);
    press(S_MONTH, 1'b1, 1);
    check_date("feb clamp", 28, 2, 2001);
    press(S_MONTH, 1'b1, 2);
    press(S_DAY, 1'b0, 27);
    check_date("apr1", 1, 4, 2001);
    press(S_DAY, 1'b0, 1);
    check_date("apr day wrap", 30, 4, 2001);

    // 6: held button, simultaneous edges, dropped carry
    do_reset();
    dif.select_item = S_DAY;
    dif.up = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_val("held up", int'(dif.day_bin), 2);
    dif.up = 1'b0;
    tick();
    dif.up = 1'b1;
    dif.down = 1'b1;
    tick();
    check_val("up_down together", int'(dif.day_bin), 2);
    dif.up = 1'b0;
    dif.down = 1'b0;
    tick();
    dif.en_1 = 1'b1;
    dif.carry_in = 1'b1;
    tick();
    dif.carry_in = 1'b0;
    check_val("carry in edit", int'(dif.day_bin), 2);
    dif.select_item = S_RUN;
    tick(); tick();
    check_val("carry not queued", int'(dif.day_bin), 2);
    dif.en_1 = 1'b0;
    dif.carry_in = 1'b1;
    tick();
    dif.carry_in = 1'b0;
    check_val("carry disabled", int'(dif.day_bin), 2);
    carry_pulse();
    check_date("carry run", 3, 1, 2001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
